// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// Handshake: a byte transfers on a posedge where rx_valid && rx_ready; rx_valid may drop at any time.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: unpacks a counted byte frame into instruction memory, then releases the core.
// Optional trailing XOR checksum byte is enabled with the LOADER_CHECKSUM_EN macro.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               RESET,
  imem_boot_loader_if.slave  bus,
  output logic               cpu_reset,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e            state_q, state_d, final_state;
  logic [15:0]       n_q, n_d, w_q, w_d, w_inc, cnt_rx;
  logic [1:0]        b_q, b_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              rx_ready, accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: rx_ready = !RESET;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                 rx_ready = !RESET;
`endif
      default:                rx_ready = 1'b0;
    endcase
  end

  assign accept       = bus.rx_valid && rx_ready;
  assign cnt_rx       = {n_q[15:8], bus.rx_data};
  assign w_inc        = w_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
  assign final_state  = S_CSUM;
`else
  assign final_state  = S_DONE;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    w_d         = w_q;
    b_d         = b_q;
    wbuf_d      = wbuf_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    // Release is registered so the core leaves reset after the last write has landed.
    cpu_reset_d = (state_q != S_DONE);
`ifdef LOADER_CHECKSUM_EN
    csum_d      = accept ? (csum_q ^ bus.rx_data) : csum_q;
`endif
    if (accept) begin
      case (state_q)
        S_HDR0: begin
          n_d[15:8] = bus.rx_data;
          state_d   = S_HDR1;
        end
        S_HDR1: begin
          n_d = cnt_rx;
          if (cnt_rx == 16'd0)                 state_d = final_state;
          else if ({1'b0, cnt_rx} > DEPTH)     state_d = S_ERROR;
          else                                 state_d = S_DATA;
        end
        S_DATA: begin
          b_d = b_q + 2'd1;
          case (b_q)
            2'd0:    wbuf_d = {bus.rx_data, 16'h0000};
            2'd1:    wbuf_d[15:8] = bus.rx_data;
            2'd2:    wbuf_d[7:0]  = bus.rx_data;
            default: begin
              im_we_d    = 1'b1;
              im_addr_d  = w_q[ADDR_W-1:0];
              im_wdata_d = {wbuf_q, bus.rx_data};
              w_d        = w_inc;
              if (w_inc == n_q) state_d = final_state;
            end
          endcase
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: state_d = ((csum_q ^ bus.rx_data) == 8'h00) ? S_DONE : S_ERROR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= S_HDR0;
      n_q         <= '0;
      w_q         <= '0;
      b_q         <= '0;
      wbuf_q      <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      w_q         <= w_d;
      b_q         <= b_d;
      wbuf_q      <= wbuf_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERROR);
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and random frames against a frame-level model of the loader (ADDR_W=4, 16-word memory).
module tb_imem_boot_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  logic       clk = 1'b0;
  logic       RESET;
  logic       cpu_reset, done, err;
  logic [2:0] dbg_state;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest expected {addr, data}
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", 64'({bus.im_addr, bus.im_wdata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    RESET        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_addr", bus.im_addr, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    @(posedge clk); #1;
    RESET = 1'b0;
    @(negedge clk);
    check("rx_ready_after_reset", bus.rx_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic new_frame(input int n);
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
  endtask

  task automatic add_word(input logic [31:0] w);
    frame_q.push_back(w[31:24]);
    frame_q.push_back(w[23:16]);
    frame_q.push_back(w[15:8]);
    frame_q.push_back(w[7:0]);
  endtask

  task automatic add_csum(input bit corrupt);
    logic [7:0] x;
    x = corrupt ? 8'($urandom_range(1, 255)) : 8'h00;
    foreach (frame_q[i]) x ^= frame_q[i];
`ifdef LOADER_CHECKSUM_EN
    frame_q.push_back(x);
`endif
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid
  task automatic drive(input int mode);
    int idx = 0;
    int spins = 0;
    bit tog = 1'b0;
    bit v, acc;
    while (idx < frame_q.size()) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.rx_valid = v;
      bus.rx_data  = v ? frame_q[idx] : 8'($urandom);
      @(negedge clk);
      acc = bus.rx_valid && bus.rx_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      spins++;
      if (spins > 4 * frame_q.size() + 64) begin
        check("drive_timeout", 64'(idx), 64'(frame_q.size()));
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  // reference model: outcome and writes derived from the frame bytes alone
  task automatic run_frame(input int mode);
    int n;
    bit bad;
    logic [7:0] x;
    n   = {frame_q[0], frame_q[1]};
    bad = (n > DEPTH);
    if (!bad) begin
      for (int k = 0; k < n; k++)
        exp_q.push_back({ADDR_W'(k), frame_q[2+4*k], frame_q[3+4*k], frame_q[4+4*k], frame_q[5+4*k]});
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (frame_q[i]) x ^= frame_q[i];
      if (x != 8'h00) bad = 1'b1;
`else
      x = 8'h00;
`endif
    end
    drive(mode);
    @(negedge clk);
    check("done_t1", done, 64'(!bad));
    check("cpu_reset_t1", cpu_reset, 1);
    @(negedge clk);
    check("done_t2", done, 64'(!bad));
    check("err_t2", err, 64'(bad));
    check("cpu_reset_t2", cpu_reset, 64'(bad));
    check("rx_ready_t2", bus.rx_ready, 0);
    check("writes_left", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    RESET        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    do_reset();

    new_frame(2); add_word(32'hDEADBEEF); add_word(32'h01234567); add_csum(0);
    run_frame(0);

    do_reset();
    new_frame(2); add_word(32'hDEADBEEF); add_word(32'h01234567); add_csum(0);
    run_frame(1);

    do_reset();
    new_frame(0); add_csum(0);
    run_frame(0);

    do_reset();
    new_frame(DEPTH);
    for (int k = 0; k < DEPTH; k++) add_word($urandom);
    add_csum(0);
    run_frame(2);

    do_reset();
    new_frame(DEPTH + 1);
    run_frame(0);

    // reset in the middle of word 1: only word 0 may be written
    do_reset();
    new_frame(2); add_word(32'hCAFEF00D);
    frame_q.push_back(8'h01); frame_q.push_back(8'h23);
    exp_q.push_back({ADDR_W'(0), 32'hCAFEF00D});
    drive(0);
    do_reset();
    check("midload_writes_left", 64'(exp_q.size()), 0);
    new_frame(1); add_word(32'h11223344); add_csum(0);
    run_frame(0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    new_frame(1); add_word(32'h11223344); add_csum(1);
    run_frame(0);
`endif

    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = (r == 7) ? int'($urandom_range(DEPTH + 1, 65535)) : int'($urandom_range(0, DEPTH));
      new_frame(n);
      if (n <= DEPTH) begin
        for (int k = 0; k < n; k++) add_word($urandom);
        add_csum($urandom_range(0, 3) == 0);
      end
      run_frame(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
